// File: rtl/forward_unit.sv
// Operand-forwarding and load-use hazard controller: tracks the destination
// registers in EX/MEM/WB and selects the freshest source for rs1 and rs2.
module forward_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_rd_we,
  input  logic        id_is_load,
  input  logic        hold,
  input  logic        flush,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic        stall,
  output logic        id_accept,
  output logic [31:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       rd_we;
    logic       is_load;
  } slot_t;

  localparam slot_t BUBBLE = '{valid: 1'b0, rd: 5'd0, rd_we: 1'b0, is_load: 1'b0};

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_EX  = 2'b11;

  slot_t       ex_q, ex_d;
  slot_t       mem_q, mem_d;
  slot_t       wb_q, wb_d;
  logic [31:0] stall_count_q, stall_count_d;

  logic        a_ex, a_mem, a_wb;
  logic        b_ex, b_mem, b_wb;
  logic [1:0]  sel_a, sel_b;

  // A slot supplies an operand only if it really writes a nonzero register.
  function automatic logic hit(input logic used, input logic [4:0] rs, input slot_t s);
    return used && (rs != 5'd0) && s.valid && s.rd_we && (s.rd != 5'd0) && (s.rd == rs);
  endfunction

  function automatic logic [1:0] pick(input logic ex, input logic mem, input logic wb);
    if (ex)       return SEL_EX;
    else if (mem) return SEL_MEM;
    else if (wb)  return SEL_WB;
    else          return SEL_RF;
  endfunction

  // Handshake: the issue stage offers an instruction with id_valid; it is
  // taken into EX on the rising edge where id_accept=1, and must be held
  // unchanged by the issue stage in any cycle where id_accept=0.
  always_comb begin
    a_ex  = hit(id_rs1_used, id_rs1, ex_q);
    a_mem = hit(id_rs1_used, id_rs1, mem_q);
    a_wb  = hit(id_rs1_used, id_rs1, wb_q);
    b_ex  = hit(id_rs2_used, id_rs2, ex_q);
    b_mem = hit(id_rs2_used, id_rs2, mem_q);
    b_wb  = hit(id_rs2_used, id_rs2, wb_q);
    sel_a = pick(a_ex, a_mem, a_wb);
    sel_b = pick(b_ex, b_mem, b_wb);

    // a_ex/b_ex already imply EX is a valid forwarding source
    stall     = id_valid && ex_q.is_load && (a_ex || b_ex);
    id_accept = id_valid && !stall && !hold && !flush;
    forward_a = (id_valid && !stall) ? sel_a : SEL_RF;
    forward_b = (id_valid && !stall) ? sel_b : SEL_RF;
  end

  always_comb begin
    ex_d          = ex_q;
    mem_d         = mem_q;
    wb_d          = wb_q;
    stall_count_d = stall ? stall_count_q + 32'd1 : stall_count_q;
    if (!hold) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (id_accept) begin
        ex_d.valid   = 1'b1;
        ex_d.rd      = id_rd;
        ex_d.rd_we   = id_rd_we;
        ex_d.is_load = id_is_load;
      end else begin
        ex_d = BUBBLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q          <= BUBBLE;
      mem_q         <= BUBBLE;
      wb_q          <= BUBBLE;
      stall_count_q <= 32'd0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_forward_unit.sv
// Directed bench for forward_unit: hand-computed forwarding selects, stalls,
// flush/hold behaviour and the stall counter.
module tb_forward_unit;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  id_rd;
  logic        id_rd_we;
  logic        id_is_load;
  logic        hold;
  logic        flush;
  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic        stall;
  logic        id_accept;
  logic [31:0] stall_count;

  int total;
  int bad;

  forward_unit dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_rd_we    (id_rd_we),
    .id_is_load  (id_is_load),
    .hold        (hold),
    .flush       (flush),
    .forward_a   (forward_a),
    .forward_b   (forward_b),
    .stall       (stall),
    .id_accept   (id_accept),
    .stall_count (stall_count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic we, input logic ld);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs1_used = u1;
    id_rs2      = rs2;
    id_rs2_used = u2;
    id_rd       = rd;
    id_rd_we    = we;
    id_is_load  = ld;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drain();
    nop();
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic check_out(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                           input logic st, input logic acc);
    check({tag, "_fa"}, {30'd0, forward_a}, {30'd0, fa});
    check({tag, "_fb"}, {30'd0, forward_b}, {30'd0, fb});
    check({tag, "_stall"}, {31'd0, stall}, {31'd0, st});
    check({tag, "_acc"}, {31'd0, id_accept}, {31'd0, acc});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    hold  = 1'b0;
    flush = 1'b0;
    nop();
    step();
    step();
    // reset state: issue an instruction while reset is held
    drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0);
    settle();
    check_out("reset", 2'b00, 2'b00, 1'b0, 1'b1);
    check("reset_cnt", stall_count, 32'd0);
    nop();
    step();
    rst = 1'b0;
    step();

    // add x5, then sub rs1=x5 rs2=x6
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd3, 1'b1, 1'b0);
    settle();
    check_out("ex_fwd", 2'b11, 2'b00, 1'b0, 1'b1);
    step();
    drain();

    // producer x7, two independents, consumer rs2=x7 -> WB
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd4, 1'b1, 1'b0);
    settle();
    check_out("wb_fwd", 2'b00, 2'b01, 1'b0, 1'b1);
    drain();

    // producer x7, one independent, consumer -> MEM
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd4, 1'b1, 1'b0);
    settle();
    check_out("mem_fwd", 2'b00, 2'b10, 1'b0, 1'b1);
    drain();

    // ld x8, consumer rs1=x8: one stall cycle then MEM forward
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd8, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
    settle();
    check_out("ld_use", 2'b00, 2'b00, 1'b1, 1'b0);
    step();
    settle();
    check_out("ld_after", 2'b10, 2'b00, 1'b0, 1'b1);
    check("ld_cnt", stall_count, 32'd1);
    step();
    drain();

    // x0 destination never forwards; unused rs2 never forwards
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0);
    settle();
    check_out("x0", 2'b00, 2'b00, 1'b0, 1'b1);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 5'd3, 1'b1, 1'b0);
    settle();
    check_out("unused", 2'b11, 2'b00, 1'b0, 1'b1);
    drain();

    // three writers of x10: youngest (EX) wins on both operands
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
      step();
    end
    drive(1'b1, 5'd10, 1'b1, 5'd10, 1'b1, 5'd3, 1'b1, 1'b0);
    settle();
    check_out("prio", 2'b11, 2'b11, 1'b0, 1'b1);
    drain();

    // flushed first writer becomes a bubble
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    flush = 1'b1;
    settle();
    check("flush_acc", {31'd0, id_accept}, 32'd0);
    step();
    flush = 1'b0;
    drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    settle();
    check_out("flush_ex", 2'b00, 2'b00, 1'b0, 1'b1);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    settle();
    check_out("flush_mem", 2'b10, 2'b00, 1'b0, 1'b1);
    drain();

    // reset clears the counter, then load under hold
    rst = 1'b1;
    settle();
    check("rst_cnt", stall_count, 32'd0);
    step();
    rst = 1'b0;
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd11, 1'b1, 5'd13, 1'b1, 5'd4, 1'b1, 1'b0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_out("hold", 2'b00, 2'b00, 1'b1, 1'b0);
      step();
    end
    check("hold_cnt", stall_count, 32'd3);
    hold = 1'b0;
    settle();
    check_out("release", 2'b00, 2'b00, 1'b1, 1'b0);
    step();
    settle();
    check_out("released", 2'b10, 2'b01, 1'b0, 1'b1);
    check("rel_cnt", stall_count, 32'd4);
    step();

    // reset asserted mid-stall
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 5'd4, 1'b1, 1'b0);
    settle();
    check("pre_rst_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    check_out("mid_rst", 2'b00, 2'b00, 1'b0, 1'b1);
    check("mid_rst_cnt", stall_count, 32'd0);
    step();
    rst = 1'b0;
    nop();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
